// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front-end: default sizes,
// FSM state encoding, matrix select codes and width helpers.
package systolic_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_N         = 4;
    localparam int DEF_DRAIN_MAX = 16;

    // wr_sel_i encodings
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of the wavefront counter t, which spans 0..2N-2.
    function automatic int t_width(input int n);
        return $clog2(2 * n);
    endfunction

    // Width of a row-major element index into an N x N matrix.
    function automatic int addr_width(input int n);
        return $clog2(n * n);
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Element-wise matrix write port.
// Handshake: a write transfers on a rising clock edge where wr_valid_i and
// wr_ready_o are both high; the requester holds valid, sel, addr and data
// stable until that edge, and ready may drop at any time without a transfer.
interface systolic_feeder_if
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N
);
    localparam int ADDR_W = addr_width(N);

    logic              wr_valid_i;
    logic              wr_ready_o;
    logic              wr_sel_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;

    modport master (
        output wr_valid_i,
        output wr_sel_i,
        output wr_addr_i,
        output wr_data_i,
        input  wr_ready_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_sel_i,
        input  wr_addr_i,
        input  wr_data_i,
        output wr_ready_o
    );

endinterface

// File: rtl/systolic_skew_lane.sv
// One skewed operand lane: picks element (t - LANE) of a stored row/column,
// or zero while the wavefront has not yet reached / has already left the lane.
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N,
    parameter int LANE   = 0,
    parameter int T_W    = t_width(DEF_N)
) (
    input  logic [T_W-1:0]      t_i,
    input  logic [N*DATA_W-1:0] vec_i,
    output logic [DATA_W-1:0]   elem_o
);

    logic [T_W-1:0] w_idx;

    // Unsigned offset with an explicit lower bound check, so no wrapped index is ever read.
    always_comb begin
        w_idx  = t_i - T_W'(LANE);
        elem_o = '0;
        if ((t_i >= T_W'(LANE)) && (w_idx < T_W'(N))) begin
            for (int k = 0; k < N; k++) begin
                if (w_idx == T_W'(k)) begin
                    elem_o = vec_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Front-end driver for the N x N systolic multiplier: buffers A and B,
// streams diagonally skewed wavefronts on start, then waits for the array.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N         = DEF_N,
    parameter int DRAIN_MAX = DEF_DRAIN_MAX
) (
    input  logic                clk_i,
    input  logic                rst_i,
    systolic_feeder_if.slave    wr,
    input  logic                start_i,
    output logic [N*DATA_W-1:0] left_o,
    output logic [N*DATA_W-1:0] up_o,
    output logic                feed_valid_o,
    input  logic                done_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output state_t              state_o
);

    localparam int T_W    = t_width(N);
    localparam int D_W    = $clog2(DRAIN_MAX + 1);
    localparam int ADDR_W = addr_width(N);

    state_t              r_state;
    state_t              w_state_next;
    logic [T_W-1:0]      r_t;
    logic [D_W-1:0]      r_drain;
    logic [DATA_W-1:0]   r_mat_a [N*N];
    logic [DATA_W-1:0]   r_mat_b [N*N];
    logic [N*DATA_W-1:0] r_left;
    logic [N*DATA_W-1:0] r_up;
    logic                r_feed_valid;
    logic                r_err;

    logic [N*DATA_W-1:0] w_row_vec [N];
    logic [N*DATA_W-1:0] w_col_vec [N];
    logic [N*DATA_W-1:0] w_left_next;
    logic [N*DATA_W-1:0] w_up_next;
    logic                w_wr_fire;
    logic                w_start;
    logic                w_feed_last;
    logic                w_timeout;

    assign wr.wr_ready_o = (r_state == ST_IDLE);
    assign w_wr_fire     = wr.wr_valid_i && wr.wr_ready_o;
    assign w_start       = (r_state == ST_IDLE) && start_i;
    assign w_feed_last   = (r_state == ST_FEED) && (r_t == T_W'(2*N - 2));
    assign w_timeout     = (r_state == ST_DRAIN) && !done_i && (r_drain == D_W'(DRAIN_MAX - 1));

    // Matrix buffers; an index with no matching entry is simply dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N*N; k++) begin
                r_mat_a[k] <= '0;
                r_mat_b[k] <= '0;
            end
        end else if (w_wr_fire) begin
            for (int k = 0; k < N*N; k++) begin
                if (wr.wr_addr_i == ADDR_W'(k)) begin
                    if (wr.wr_sel_i == SEL_A) r_mat_a[k] <= wr.wr_data_i;
                    if (wr.wr_sel_i == SEL_B) r_mat_b[k] <= wr.wr_data_i;
                end
            end
        end
    end

    // Regroup buffers into per-row (A) and per-column (B) vectors for the lanes.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            w_row_vec[r] = '0;
            w_col_vec[r] = '0;
            for (int j = 0; j < N; j++) begin
                w_row_vec[r][j*DATA_W +: DATA_W] = r_mat_a[r*N + j];
                w_col_vec[r][j*DATA_W +: DATA_W] = r_mat_b[j*N + r];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        systolic_skew_lane #(.DATA_W(DATA_W), .N(N), .LANE(g), .T_W(T_W)) u_row (
            .t_i    (r_t),
            .vec_i  (w_row_vec[g]),
            .elem_o (w_left_next[g*DATA_W +: DATA_W])
        );
        systolic_skew_lane #(.DATA_W(DATA_W), .N(N), .LANE(g), .T_W(T_W)) u_col (
            .t_i    (r_t),
            .vec_i  (w_col_vec[g]),
            .elem_o (w_up_next[g*DATA_W +: DATA_W])
        );
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; done_i only matters once the feed is over.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_next = ST_FEED;
            ST_FEED:  if (w_feed_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (done_i || w_timeout) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Wavefront counter t and drain timeout counter, both zero outside their state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_t     <= '0;
            r_drain <= '0;
        end else begin
            r_t     <= (r_state == ST_FEED)  ? r_t + T_W'(1)     : '0;
            r_drain <= (r_state == ST_DRAIN) ? r_drain + D_W'(1) : '0;
        end
    end

    // Registered operand outputs: wavefront t appears the cycle after t is current.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_left       <= '0;
            r_up         <= '0;
            r_feed_valid <= 1'b0;
        end else begin
            r_left       <= (r_state == ST_FEED) ? w_left_next : '0;
            r_up         <= (r_state == ST_FEED) ? w_up_next   : '0;
            r_feed_valid <= (r_state == ST_FEED);
        end
    end

    // Sticky timeout flag, cleared by the next accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          r_err <= 1'b0;
        else if (w_start)   r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
    end

    assign left_o       = r_left;
    assign up_o         = r_up;
    assign feed_valid_o = r_feed_valid;
    assign busy_o       = (r_state == ST_FEED) || (r_state == ST_DRAIN);
    assign done_o       = (r_state == ST_DONE);
    assign err_o        = r_err;
    assign state_o      = r_state;

endmodule
